// File: rtl/axis_ema_mc.sv
// rtl/axis_ema_mc.sv - multi-channel AXI4-Stream exponential moving average filter
// Optional build macro: EMA_ROUND_EN (round-half-up output instead of truncation).
// Each channel keeps an unsigned accumulator with FRAC_W guard bits.
// Samples arrive round-robin across channels, and TLAST restarts the rotation at channel 0.
module axis_ema_mc #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 1,
  parameter int ALPHA_SHIFT = 2,
  parameter int FRAC_W      = 8,
  parameter int INIT_VALUE  = 1000,
  parameter int SEED_FIRST  = 0,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int KEEP_W     = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic [KEEP_W-1:0] S_AXIS_TKEEP,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic [KEEP_W-1:0] M_AXIS_TKEEP,
  output logic              M_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [CH_W-1:0]   M_AXIS_TDEST
);

  localparam int AW = DATA_W + FRAC_W;
  localparam logic [AW-1:0] INIT_ACC = AW'(INIT_VALUE) << FRAC_W;

  logic [AW-1:0]     acc_q [NUM_CH];
  logic [NUM_CH-1:0] seeded_q;
  logic [CH_W-1:0]   ch_ptr_q;
  logic [CH_W-1:0]   ch_ptr_d;
  logic [AW-1:0]     acc_d;
  logic [DATA_W-1:0] out_d;

  logic              m_tvalid_q;
  logic [DATA_W-1:0] m_tdata_q;
  logic [KEEP_W-1:0] m_tkeep_q;
  logic              m_tlast_q;
  logic [CH_W-1:0]   m_tdest_q;

  logic              accept;
  logic [AW-1:0]     acc_cur;
  logic [AW-1:0]     x_fix;
  logic signed [AW:0] diff;
  logic signed [AW:0] step;
  logic [AW:0]       sum;
  logic              unused_sum_msb;

  // Ready depends only on the output register and downstream ready, never on TVALID.
  assign S_AXIS_TREADY = ~m_tvalid_q | M_AXIS_TREADY;
  assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;

  assign M_AXIS_TVALID = m_tvalid_q;
  assign M_AXIS_TDATA  = m_tdata_q;
  assign M_AXIS_TKEEP  = m_tkeep_q;
  assign M_AXIS_TLAST  = m_tlast_q;
  assign M_AXIS_TDEST  = m_tdest_q;

  // Filter step for the channel the pointer selects; the result always lies between acc and x.
  always_comb begin
    acc_cur = acc_q[ch_ptr_q];
    x_fix   = AW'(S_AXIS_TDATA) << FRAC_W;
    diff    = $signed({1'b0, x_fix}) - $signed({1'b0, acc_cur});
    step    = diff >>> ALPHA_SHIFT;
    sum     = {1'b0, acc_cur} + $unsigned(step);
    acc_d   = sum[AW-1:0];
    if ((SEED_FIRST != 0) && !seeded_q[ch_ptr_q]) begin
      acc_d = x_fix;
    end
  end
  assign unused_sum_msb = sum[AW];

`ifdef EMA_ROUND_EN
  logic [AW:0] rnd;
  logic        unused_rnd_frac;

  // Round half up on the output only, and saturate if the rounding carry leaves the sample range.
  always_comb begin
    rnd   = {1'b0, acc_d} + ((AW + 1)'(1) << (FRAC_W - 1));
    out_d = rnd[AW] ? {DATA_W{1'b1}} : rnd[AW-1:FRAC_W];
  end
  assign unused_rnd_frac = ^rnd[FRAC_W-1:0];
`else
  // Truncate the guard fraction bits.
  always_comb begin
    out_d = acc_d[AW-1:FRAC_W];
  end
`endif

  // Advance round-robin; TLAST always restarts at channel 0.
  always_comb begin
    if (S_AXIS_TLAST || (ch_ptr_q == CH_W'(NUM_CH - 1))) begin
      ch_ptr_d = '0;
    end else begin
      ch_ptr_d = ch_ptr_q + CH_W'(1);
    end
  end

  // Channel state: accumulators, seed flags and pointer move only on an accepted beat.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= INIT_ACC;
      end
      seeded_q <= '0;
      ch_ptr_q <= '0;
    end else if (accept) begin
      acc_q[ch_ptr_q]    <= acc_d;
      seeded_q[ch_ptr_q] <= 1'b1;
      ch_ptr_q           <= ch_ptr_d;
    end
  end

  // Output register: load on accept, hold under backpressure, drop valid once it drains.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tdest_q  <= '0;
    end else if (accept) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= out_d;
      m_tkeep_q  <= S_AXIS_TKEEP;
      m_tlast_q  <= S_AXIS_TLAST;
      m_tdest_q  <= ch_ptr_q;
    end else if (M_AXIS_TREADY) begin
      m_tvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_ema_mc.sv
// tb/tb_axis_ema_mc.sv - self-checking bench for axis_ema_mc across four configurations
module tb_axis_ema_mc;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [3:0][31:0] s_tdata;
  logic [3:0][3:0]  s_tkeep;
  logic [3:0]       s_tlast;
  logic [3:0]       s_tvalid;
  logic [3:0]       s_tready;
  logic [3:0][31:0] m_tdata;
  logic [3:0][3:0]  m_tkeep;
  logic [3:0]       m_tlast;
  logic [3:0]       m_tvalid;
  logic [3:0]       m_tready;
  logic [0:0]       dest0, dest1, dest3;
  logic [1:0]       dest2;
  logic [3:0][1:0]  m_tdest;

  assign m_tdest[0] = {1'b0, dest0};
  assign m_tdest[1] = {1'b0, dest1};
  assign m_tdest[2] = dest2;
  assign m_tdest[3] = {1'b0, dest3};

  axis_ema_mc #(.NUM_CH(1)) u_ch1 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(s_tdata[0]), .S_AXIS_TKEEP(s_tkeep[0]), .S_AXIS_TLAST(s_tlast[0]),
    .S_AXIS_TVALID(s_tvalid[0]), .S_AXIS_TREADY(s_tready[0]),
    .M_AXIS_TDATA(m_tdata[0]), .M_AXIS_TKEEP(m_tkeep[0]), .M_AXIS_TLAST(m_tlast[0]),
    .M_AXIS_TVALID(m_tvalid[0]), .M_AXIS_TREADY(m_tready[0]), .M_AXIS_TDEST(dest0));

  axis_ema_mc #(.NUM_CH(2)) u_ch2 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(s_tdata[1]), .S_AXIS_TKEEP(s_tkeep[1]), .S_AXIS_TLAST(s_tlast[1]),
    .S_AXIS_TVALID(s_tvalid[1]), .S_AXIS_TREADY(s_tready[1]),
    .M_AXIS_TDATA(m_tdata[1]), .M_AXIS_TKEEP(m_tkeep[1]), .M_AXIS_TLAST(m_tlast[1]),
    .M_AXIS_TVALID(m_tvalid[1]), .M_AXIS_TREADY(m_tready[1]), .M_AXIS_TDEST(dest1));

  axis_ema_mc #(.NUM_CH(3)) u_ch3 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(s_tdata[2]), .S_AXIS_TKEEP(s_tkeep[2]), .S_AXIS_TLAST(s_tlast[2]),
    .S_AXIS_TVALID(s_tvalid[2]), .S_AXIS_TREADY(s_tready[2]),
    .M_AXIS_TDATA(m_tdata[2]), .M_AXIS_TKEEP(m_tkeep[2]), .M_AXIS_TLAST(m_tlast[2]),
    .M_AXIS_TVALID(m_tvalid[2]), .M_AXIS_TREADY(m_tready[2]), .M_AXIS_TDEST(dest2));

  axis_ema_mc #(.NUM_CH(1), .SEED_FIRST(1)) u_seed (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(s_tdata[3]), .S_AXIS_TKEEP(s_tkeep[3]), .S_AXIS_TLAST(s_tlast[3]),
    .S_AXIS_TVALID(s_tvalid[3]), .S_AXIS_TREADY(s_tready[3]),
    .M_AXIS_TDATA(m_tdata[3]), .M_AXIS_TKEEP(m_tkeep[3]), .M_AXIS_TLAST(m_tlast[3]),
    .M_AXIS_TVALID(m_tvalid[3]), .M_AXIS_TREADY(m_tready[3]), .M_AXIS_TDEST(dest3));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: per-channel accumulator in fixed point with 8 fraction bits, alpha = 1/4.
  int     nch   [4] = '{1, 2, 3, 1};
  int     seedp [4] = '{0, 0, 0, 1};
  longint macc  [4][16];
  bit     mseed [4][16];
  int     mptr  [4];
  longint e_data[4][64];
  int     e_keep[4][64], e_last[4][64], e_dest[4][64];
  int     head[4], tail[4];
  longint log_data[4][64];
  int     log_dest[4][64], log_cyc[4][64];
  int     n_out[4], acc_cnt[4];
  int     cyc = 0;
  bit     rst_prev = 1'b0;

  always @(negedge ACLK) begin : compare
    longint d, st, an, r;
    int c;
    cyc++;
    if (!ARESETN) begin
      for (int k = 0; k < 4; k++) begin
        head[k] = 0; tail[k] = 0; mptr[k] = 0;
        for (int j = 0; j < 16; j++) begin
          macc[k][j] = 1000 * 256;
          mseed[k][j] = 1'b0;
        end
      end
      rst_prev = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (rst_prev) begin
          chk($sformatf("rst_valid%0d", k), m_tvalid[k], 0);
          chk($sformatf("rst_data%0d", k), m_tdata[k], 0);
          chk($sformatf("rst_kld%0d", k), {m_tkeep[k], m_tlast[k], m_tdest[k]}, 0);
        end
        chk($sformatf("s_tready%0d", k), s_tready[k], !m_tvalid[k] || m_tready[k]);
        if (m_tvalid[k]) begin
          if (head[k] == tail[k]) begin
            chk($sformatf("spurious_beat%0d", k), 1, 0);
          end else begin
            chk($sformatf("data%0d", k), m_tdata[k], e_data[k][head[k] % 64]);
            chk($sformatf("keep%0d", k), m_tkeep[k], e_keep[k][head[k] % 64]);
            chk($sformatf("last%0d", k), m_tlast[k], e_last[k][head[k] % 64]);
            chk($sformatf("dest%0d", k), m_tdest[k], e_dest[k][head[k] % 64]);
            if (m_tready[k]) begin
              log_data[k][n_out[k]] = m_tdata[k];
              log_dest[k][n_out[k]] = m_tdest[k];
              log_cyc[k][n_out[k]]  = cyc;
              n_out[k]++;
              head[k]++;
            end
          end
        end
        if (s_tvalid[k] && s_tready[k]) begin
          acc_cnt[k]++;
          c = mptr[k];
          if (seedp[k] != 0 && !mseed[k][c]) begin
            an = longint'(s_tdata[k]) * 256;
          end else begin
            d  = longint'(s_tdata[k]) * 256 - macc[k][c];
            st = (d >= 0) ? d / 4 : -((-d + 3) / 4);
            an = macc[k][c] + st;
          end
          mseed[k][c] = 1'b1;
          macc[k][c]  = an;
`ifdef EMA_ROUND_EN
          r = (an + 128) / 256;
          if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
`else
          r = an / 256;
`endif
          e_data[k][tail[k] % 64] = r;
          e_keep[k][tail[k] % 64] = s_tkeep[k];
          e_last[k][tail[k] % 64] = s_tlast[k];
          e_dest[k][tail[k] % 64] = c;
          tail[k]++;
          mptr[k] = (s_tlast[k] || c == nch[k] - 1) ? 0 : c + 1;
        end
      end
      rst_prev = 1'b0;
    end
  end

  task automatic send(input int k, input int dv, input bit l);
    int n = 0;
    s_tvalid[k] = 1'b1;
    s_tdata[k]  = dv;
    s_tkeep[k]  = dv[3:0];
    s_tlast[k]  = l;
    do begin
      @(negedge ACLK);
      n++;
    end while (!s_tready[k] && n < 50);
    if (!s_tready[k]) chk($sformatf("send_timeout%0d", k), 0, 1);
    @(posedge ACLK); #1;
    s_tvalid[k] = 1'b0;
    s_tlast[k]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  int c0, n0;

  initial begin
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0; m_tready = '1;
    idle(3);
    ARESETN = 1'b1;
    idle(2);

    // Single channel, full throughput.
    send(0, 2000, 0); send(0, 2000, 0); send(0, 2000, 0);
    idle(3);
    // Two channels interleaved.
    send(1, 1000, 0); send(1, 0, 0); send(1, 1000, 0); send(1, 0, 0);
    idle(3);
    // Three channels, TLAST on first beat restarts the rotation.
    send(2, 300, 1); send(2, 600, 0); send(2, 900, 0);
    idle(3);
    // Seeded single channel.
    send(3, 4000, 0); send(3, 0, 0);
    idle(3);

    // Backpressure on channel-1 instance.
    c0 = acc_cnt[0];
    m_tready[0] = 1'b0;
    s_tvalid[0] = 1'b1; s_tdata[0] = 3000; s_tkeep[0] = 4'h3; s_tlast[0] = 1'b0;
    idle(1);
    s_tdata[0] = 3100; s_tkeep[0] = 4'hC;
    idle(4);
    chk("bp_accepts", acc_cnt[0] - c0, 1);
    chk("bp_s_tready", s_tready[0], 0);
`ifdef EMA_ROUND_EN
    chk("bp_held_data", m_tdata[0], 1934);
`else
    chk("bp_held_data", m_tdata[0], 1933);
`endif
    m_tready[0] = 1'b1;
    idle(1);
    s_tvalid[0] = 1'b0;
    chk("bp_accepts_after", acc_cnt[0] - c0, 2);
    idle(3);
    chk("bp_outputs", n_out[0], 5);

    // Mid-stream reset with a beat held.
    m_tready[0] = 1'b0;
    send(0, 500, 0);
    ARESETN = 1'b0;
    idle(1);
    ARESETN = 1'b1;
    m_tready[0] = 1'b1;
    n0 = n_out[0];
    send(0, 2000, 0);
    idle(3);
    chk("rst_outputs", n_out[0], n0 + 1);
    chk("rst_resume_data", log_data[0][n0], 1250);
    chk("rst_resume_dest", log_dest[0][n0], 0);

    // Hand-computed expectations that pin the model.
    chk("t1_o0", log_data[0][0], 1250);
`ifdef EMA_ROUND_EN
    chk("t1_o1", log_data[0][1], 1438);
    chk("t2_o3", log_data[1][3], 563);
`else
    chk("t1_o1", log_data[0][1], 1437);
    chk("t2_o3", log_data[1][3], 562);
`endif
    chk("t1_o2", log_data[0][2], 1578);
    chk("t1_rate", log_cyc[0][2] - log_cyc[0][0], 2);
    chk("t2_o0", log_data[1][0], 1000);
    chk("t2_o1", log_data[1][1], 750);
    chk("t2_o2", log_data[1][2], 1000);
    chk("t2_dests", {log_dest[1][0][0], log_dest[1][1][0], log_dest[1][2][0], log_dest[1][3][0]}, 4'b0101);
    chk("t3_dest_a", log_dest[2][0], 0);
    chk("t3_dest_b", log_dest[2][1], 0);
    chk("t3_dest_c", log_dest[2][2], 1);
    chk("t3_data_a", log_data[2][0], 825);
    chk("t4_o0", log_data[3][0], 4000);
    chk("t4_o1", log_data[3][1], 3000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drained%0d", k), tail[k] - head[k], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_ema_mc.md
Name: axis_ema_mc

Overview:
- Parametrised multi-channel exponential moving average (EMA) filter on AXI4-Stream; the next generation of the team's fixed alpha=1/4 single-channel EMA.
- Computes y[n] = y[n-1] + (x[n] - y[n-1]) * 2^-ALPHA_SHIFT per channel, using fractional guard bits.
- Samples are time-interleaved round-robin across NUM_CH channels; frames are delimited by TLAST.
- Fully registered output stage with correct AXIS backpressure. Sits between a DMA MM2S and S2MM path.

Parameters:
- DATA_W, 32, sample width (unsigned)
- NUM_CH, 1, interleaved channel count, 1..16
- ALPHA_SHIFT, 2, alpha = 2^-ALPHA_SHIFT, range 1..15
- FRAC_W, 8, guard fraction bits held in each accumulator
- INIT_VALUE, 1000, reset/seed value of every channel (integer units)
- SEED_FIRST, 0, 1 = first sample of a channel after reset loads the accumulator directly

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset; synchronous, active-low; clock ACLK
- S_AXIS_TDATA  in  DATA_W  input sample
- S_AXIS_TKEEP  in  DATA_W/8  byte keep
- S_AXIS_TLAST  in  1  end of frame
- S_AXIS_TVALID  in  1  input valid
- S_AXIS_TREADY  out  1  input ready
- M_AXIS_TDATA  out  DATA_W  filtered sample
- M_AXIS_TKEEP  out  DATA_W/8  registered copy of input TKEEP
- M_AXIS_TLAST  out  1  registered copy of input TLAST
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  output ready
- M_AXIS_TDEST  out  CH_W=max(1,clog2(NUM_CH))  channel of the output beat

Behaviour:
- Reset: M_AXIS_TVALID=0; M_AXIS_TDATA/TKEEP/TLAST/TDEST=0; ch_ptr=0; every acc[c]=INIT_VALUE<<FRAC_W; every seeded[c]=0. Reset mid-stream discards any held output beat.
- Accumulators: AW=DATA_W+FRAC_W bits, unsigned.
- Difference: diff = (x<<FRAC_W) - acc, computed signed at AW+1 bits.
- Update: acc_new = acc + (diff >>> ALPHA_SHIFT), arithmetic shift. Result always lies between acc and x, so no overflow.
- Output: M_AXIS_TDATA = acc_new[AW-1:FRAC_W] (truncate).
- Seeding: if SEED_FIRST=1 and seeded[c]=0, then acc_new = x<<FRAC_W and seeded[c] is set to 1.
- Handshake:
  - S_AXIS_TREADY = ~M_AXIS_TVALID | M_AXIS_TREADY, with no combinational path from TVALID.
  - Accept occurs when S_AXIS_TVALID & S_AXIS_TREADY.
  - On accept: acc[ch_ptr] <= acc_new; output register loads in the same edge; M_AXIS_TVALID <= 1. Latency 1 cycle.
  - Output beat held stable while M_AXIS_TVALID & ~M_AXIS_TREADY.
  - M_AXIS_TVALID clears on an output handshake with no simultaneous accept.
  - Simultaneous output handshake and accept: register reloads and TVALID stays 1, giving full throughput of 1 beat/cycle.
- Channel pointer:
  - After each accept, ch_ptr <= (ch_ptr==NUM_CH-1) ? 0 : ch_ptr+1.
  - If the accepted beat has TLAST=1, ch_ptr <= 0 regardless; this overrides wrap.
  - M_AXIS_TDEST = channel used for that beat.
  - NUM_CH=1: ch_ptr is constant 0.
- Idle input (TVALID=0): accumulators and ch_ptr hold.
- TKEEP does not gate arithmetic; it is passed through only.

Optional Feature:
- Macro: EMA_ROUND_EN.
- Defined: output = (acc_new + 2^(FRAC_W-1))[AW-1:FRAC_W], round half up. The accumulator itself stays unrounded. Saturate to 2^DATA_W-1 if the rounding carry overflows.
- Undefined: truncation as above. Applies to the output only; accumulator behaviour is identical in both builds.

Test Plan:
- Defaults, NUM_CH=1, inputs 2000,2000,2000 with M_AXIS_TREADY=1 -> outputs 1250,1437,1578 (truncate). With EMA_ROUND_EN: 1250,1438,1578. One beat per cycle, latency 1.
- NUM_CH=2, inputs 1000,0,1000,0 -> outputs 1000(TDEST0), 750(TDEST1), 1000(TDEST0), 562(TDEST1).
- NUM_CH=3, beats A(TLAST=1) then B, C -> A on TDEST0, B on TDEST0, C on TDEST1; the pointer resets after TLAST.
- Backpressure: hold M_AXIS_TREADY=0 for 5 cycles with input valid -> exactly one beat accepted, S_AXIS_TREADY=0, output data stable. Release -> stream resumes with no loss or duplication.
- SEED_FIRST=1, NUM_CH=1, inputs 4000,0 -> outputs 4000,3000.
- Assert ARESETN=0 mid-stream for 1 cycle -> M_AXIS_TVALID=0 next cycle. Next input 2000 -> output 1250 (accumulator back to 1000), TDEST=0.
